// File: rtl/sea_iter_dec.sv
// sea_iter_dec: iterative SEA(96,8) decryption core, one Feistel round per
// clock on 48-bit halves. The optional abort input is enabled by defining
// SEA_ITER_ABORT_EN; the default build has no abort port.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. in_ready is high only in IDLE. Once out_valid rises, it stays
// high and pt_l/pt_r stay stable until the edge where out_ready is high.
module sea_iter_dec #(
    parameter int NR = 52
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SEA_ITER_ABORT_EN
    input  logic        abort,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] ci_l,
    input  logic [47:0] ci_r,
    input  logic [47:0] ki,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] pt_l,
    output logic [47:0] pt_r,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] NR_LAST = 8'(NR - 1);

    // Per-word (byte) addition mod 256 with no carry between words.
    function automatic logic [47:0] word_add(input logic [47:0] x, input logic [47:0] k);
        logic [47:0] y;
        y = '0;
        for (int j = 0; j < 6; j++) begin
            y[8*j +: 8] = x[8*j +: 8] + k[8*j +: 8];
        end
        return y;
    endfunction

    // 3-bit substitution table applied to each bitslice of a word triple.
    function automatic logic [2:0] sbox3(input logic [2:0] n);
        logic [2:0] o;
        case (n)
            3'd0: o = 3'd0;
            3'd1: o = 3'd5;
            3'd2: o = 3'd6;
            3'd3: o = 3'd7;
            3'd4: o = 3'd4;
            3'd5: o = 3'd3;
            3'd6: o = 3'd1;
            default: o = 3'd2;
        endcase
        return o;
    endfunction

    // Bitsliced S layer: bit p of words 3m, 3m+1, 3m+2 forms one nibble.
    function automatic logic [47:0] s_layer(input logic [47:0] x);
        logic [47:0] y;
        logic [2:0]  n;
        logic [2:0]  o;
        y = '0;
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 8; p++) begin
                n = {x[24*m + 16 + p], x[24*m + 8 + p], x[24*m + p]};
                o = sbox3(n);
                y[24*m + p]      = o[0];
                y[24*m + 8 + p]  = o[1];
                y[24*m + 16 + p] = o[2];
            end
        end
        return y;
    endfunction

    // Word rotations: first word of each triple right by 1, last word left by 1.
    function automatic logic [47:0] r_layer(input logic [47:0] x);
        logic [47:0] y;
        logic [7:0]  w0;
        logic [7:0]  w2;
        y = x;
        for (int m = 0; m < 2; m++) begin
            w0 = x[24*m +: 8];
            w2 = x[24*m + 16 +: 8];
            y[24*m +: 8]      = {w0[0], w0[7:1]};
            y[24*m + 16 +: 8] = {w2[6:0], w2[7]};
        end
        return y;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [47:0] l_q, l_d;
    logic [47:0] r_q, r_d;
    logic [47:0] key_q, key_d;
    logic [47:0] pt_l_q, pt_l_d;
    logic [47:0] pt_r_q, pt_r_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;

    logic        abort_req;
    logic [47:0] round_key;
    logic [47:0] f_out;
    logic [47:0] l_next;
    logic [47:0] r_next;

`ifdef SEA_ITER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // One inverse Feistel round using the current counter as round index;
    // the word rotate-down is a right rotation of the 48-bit half by 8.
    always_comb begin
        round_key = key_q ^ {40'b0, cnt_q};
        f_out     = r_layer(s_layer(word_add(l_q, round_key)));
        l_next    = {r_q[7:0] ^ f_out[7:0], r_q[47:8] ^ f_out[47:8]};
        r_next    = l_q;
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        key_d       = key_q;
        pt_l_d      = pt_l_q;
        pt_r_d      = pt_r_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    l_d     = ci_l;
                    r_d     = ci_r;
                    key_d   = ki;
                    cnt_d   = NR_LAST;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    cnt_d       = 8'd0;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                    pt_l_d      = '0;
                    pt_r_d      = '0;
                    state_d     = ST_IDLE;
                end else begin
                    l_d = l_next;
                    r_d = r_next;
                    if (cnt_q == 8'd0) begin
                        pt_l_d      = l_next;
                        pt_r_d      = r_next;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_DONE: begin
                if (abort_req) begin
                    cnt_d       = 8'd0;
                    out_valid_d = 1'b0;
                    pt_l_d      = '0;
                    pt_r_d      = '0;
                    state_d     = ST_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Register all controller state, datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            l_q         <= '0;
            r_q         <= '0;
            key_q       <= '0;
            pt_l_q      <= '0;
            pt_r_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            key_q       <= key_d;
            pt_l_q      <= pt_l_d;
            pt_r_q      <= pt_r_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign pt_l      = pt_l_q;
    assign pt_r      = pt_r_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sea_iter_dec.sv
// tb_sea_iter_dec: directed bench for sea_iter_dec with an NR=1 instance for
// hand-computed vectors and an NR=52 instance driven from an encryptor model.
module tb_sea_iter_dec;

    localparam int NR_B = 52;
    localparam logic [2:0] SB [8] = '{3'd0, 3'd5, 3'd6, 3'd7, 3'd4, 3'd3, 3'd1, 3'd2};

    logic clk = 1'b0;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [47:0] a_ci_l, a_ci_r, a_ki, a_pt_l, a_pt_r;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [47:0] b_ci_l, b_ci_r, b_ki, b_pt_l, b_pt_r;
`ifdef SEA_ITER_ABORT_EN
    logic        a_abort, b_abort;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [95:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    sea_iter_dec #(.NR(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef SEA_ITER_ABORT_EN
        .abort(a_abort),
`endif
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .ci_l(a_ci_l), .ci_r(a_ci_r), .ki(a_ki),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .pt_l(a_pt_l), .pt_r(a_pt_r), .busy(a_busy)
    );

    sea_iter_dec #(.NR(NR_B)) u_dut52 (
        .clk(clk), .rst_n(rst_n),
`ifdef SEA_ITER_ABORT_EN
        .abort(b_abort),
`endif
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .ci_l(b_ci_l), .ci_r(b_ci_r), .ki(b_ki),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .pt_l(b_pt_l), .pt_r(b_pt_r), .busy(b_busy)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- encryptor model ----------------
    function automatic logic [47:0] m_f(input logic [47:0] x, input logic [47:0] k);
        logic [7:0]  w [6];
        logic [7:0]  v [6];
        logic [2:0]  n;
        logic [2:0]  o;
        logic [47:0] y;
        for (int j = 0; j < 6; j++) begin
            w[j] = x[8*j +: 8] + k[8*j +: 8];
            v[j] = 8'd0;
        end
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 8; p++) begin
                n = {w[3*m+2][p], w[3*m+1][p], w[3*m][p]};
                o = SB[n];
                v[3*m][p]   = o[0];
                v[3*m+1][p] = o[1];
                v[3*m+2][p] = o[2];
            end
            v[3*m]   = (v[3*m] >> 1) | (v[3*m] << 7);
            v[3*m+2] = (v[3*m+2] << 1) | (v[3*m+2] >> 7);
        end
        y = '0;
        for (int j = 0; j < 6; j++) y[8*j +: 8] = v[j];
        return y;
    endfunction

    // Encrypt: L' = R, R' = rot_up(L) ^ f(R, K_i), rounds 0..NR-1.
    function automatic logic [95:0] m_enc(input logic [47:0] pl, input logic [47:0] pr,
                                          input logic [47:0] k);
        logic [47:0] a, b, c;
        a = pl;
        b = pr;
        for (int i = 0; i < NR_B; i++) begin
            c = b;
            b = {a[39:0], a[47:40]} ^ m_f(b, k ^ 48'(i));
            a = c;
        end
        return {a, b};
    endfunction

    function automatic logic [47:0] rnd48();
        return 48'({$urandom(), $urandom()});
    endfunction

    // ---------------- driver tasks (NR=52 instance) ----------------
    task automatic b_accept(input logic [47:0] l, input logic [47:0] r, input logic [47:0] k);
        int guard;
        guard = 0;
        while (!b_in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_ready", 48'(b_in_ready), 48'd1);
        b_in_valid = 1'b1;
        b_ci_l = l;
        b_ci_r = r;
        b_ki   = k;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_ci_l = rnd48();
        b_ci_r = rnd48();
        b_ki   = rnd48();
    endtask

    // Waits for out_valid after an accept; checks latency and in_ready/busy.
    task automatic b_wait_done(input string tag);
        int lat;
        int viol;
        lat  = 0;
        viol = 0;
        while (!b_out_valid && lat < 300) begin
            if (b_in_ready || !b_busy) viol++;
            @(posedge clk); #1;
            lat++;
        end
        if (b_in_ready || b_busy) viol++;
        check({tag, "_latency"}, 48'(lat), 48'(NR_B));
        check({tag, "_run_flags"}, 48'(viol), 48'd0);
    endtask

    task automatic b_compare(input string tag);
        logic [95:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 48'd0, 48'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_pt_l"}, b_pt_l, e[95:48]);
            check({tag, "_pt_r"}, b_pt_r, e[47:0]);
        end
    endtask

    // Full block with out_ready high: encrypt, send, check result and release.
    task automatic b_block(input string tag, input logic [47:0] pl, input logic [47:0] pr,
                           input logic [47:0] k);
        logic [95:0] ct;
        ct = m_enc(pl, pr, k);
        exp_q.push_back({pl, pr});
        b_out_ready = 1'b1;
        b_accept(ct[95:48], ct[47:0], k);
        b_wait_done(tag);
        b_compare(tag);
        @(posedge clk); #1;
        check({tag, "_released"}, 48'(b_out_valid), 48'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [47:0] pl, pr, k, hold_l, hold_r;
        logic [95:0] ct;
        int stable_bad;
        int rises;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_ci_l = '0; a_ci_r = '0; a_ki = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_ci_l = '0; b_ci_r = '0; b_ki = '0;
`ifdef SEA_ITER_ABORT_EN
        a_abort = 1'b0;
        b_abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 48'(b_out_valid), 48'd0);
        check("rst_busy", 48'(b_busy), 48'd0);
        check("rst_in_ready", 48'(b_in_ready), 48'd1);
        check("rst_pt_l", b_pt_l, 48'd0);
        check("rst_pt_r", b_pt_r, 48'd0);
        check("rst1_in_ready", 48'(a_in_ready), 48'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // NR=1, all-zero block and key.
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("nr1_run_valid", 48'(a_out_valid), 48'd0);
        check("nr1_run_in_ready", 48'(a_in_ready), 48'd0);
        @(posedge clk); #1;
        check("nr1_zero_valid", 48'(a_out_valid), 48'd1);
        check("nr1_zero_pt_l", a_pt_l, 48'd0);
        check("nr1_zero_pt_r", a_pt_r, 48'd0);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check("nr1_release", 48'(a_out_valid), 48'd0);
        check("nr1_idle_ready", 48'(a_in_ready), 48'd1);

        // NR=1, key = 1.
        a_in_valid = 1'b1;
        a_ki = 48'h000000000001;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_ki = 48'hFFFFFFFFFFFF;
        @(posedge clk); #1;
        check("nr1_key1_valid", 48'(a_out_valid), 48'd1);
        check("nr1_key1_pt_l", a_pt_l, 48'h800000000200);
        check("nr1_key1_pt_r", a_pt_r, 48'd0);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;

        // NR=52 round trips through the encryptor model.
        b_block("rt0", 48'h0123456789AB, 48'hCDEF01234567, 48'h0F1E2D3C4B5A);
        b_block("rt1", 48'hFFFFFFFFFFFF, 48'h000000000000, 48'hFFFFFFFFFFFF);
        for (int t = 0; t < 3; t++) begin
            b_block($sformatf("rand%0d", t), rnd48(), rnd48(), rnd48());
        end

        // Stall in DONE with out_ready low; a new offer must wait.
        pl = 48'h112233445566; pr = 48'h778899AABBCC; k = 48'hA5A55A5AA5A5;
        ct = m_enc(pl, pr, k);
        exp_q.push_back({pl, pr});
        b_out_ready = 1'b0;
        b_accept(ct[95:48], ct[47:0], k);
        b_wait_done("stall");
        hold_l = b_pt_l;
        hold_r = b_pt_r;
        b_compare("stall");
        pl = rnd48(); pr = rnd48(); k = rnd48();
        ct = m_enc(pl, pr, k);
        b_in_valid = 1'b1;
        b_ci_l = ct[95:48]; b_ci_r = ct[47:0]; b_ki = k;
        stable_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (b_pt_l !== hold_l || b_pt_r !== hold_r || b_out_valid !== 1'b1 ||
                b_in_ready !== 1'b0 || b_busy !== 1'b0) stable_bad++;
        end
        check("stall_stable", 48'(stable_bad), 48'd0);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", 48'(b_out_valid), 48'd0);
        check("stall_release_ready", 48'(b_in_ready), 48'd1);
        exp_q.push_back({pl, pr});
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        check("second_accepted", 48'(b_busy), 48'd1);
        b_wait_done("second");
        b_compare("second");
        @(posedge clk); #1;

        // Reset in the middle of a run.
        b_accept(rnd48(), rnd48(), rnd48());
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 48'(b_out_valid), 48'd0);
        check("mid_rst_busy", 48'(b_busy), 48'd0);
        check("mid_rst_ready", 48'(b_in_ready), 48'd1);
        check("mid_rst_pt_l", b_pt_l, 48'd0);
        check("mid_rst_pt_r", b_pt_r, 48'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rises = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (b_out_valid) rises++;
        end
        check("mid_rst_no_output", 48'(rises), 48'd0);
        b_block("after_rst", 48'hDEADBEEFCAFE, 48'h0BADF00D1234, 48'h13579BDF2468);

`ifdef SEA_ITER_ABORT_EN
        // Abort in the middle of a run.
        b_accept(rnd48(), rnd48(), rnd48());
        repeat (10) @(posedge clk);
        #1;
        b_abort = 1'b1;
        @(posedge clk); #1;
        b_abort = 1'b0;
        check("abort_ready", 48'(b_in_ready), 48'd1);
        check("abort_busy", 48'(b_busy), 48'd0);
        check("abort_valid", 48'(b_out_valid), 48'd0);
        check("abort_pt_l", b_pt_l, 48'd0);
        rises = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (b_out_valid) rises++;
        end
        check("abort_no_output", 48'(rises), 48'd0);
        b_block("after_abort", rnd48(), rnd48(), rnd48());
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sea_iter_dec.md
Name: sea_iter_dec

Overview:
- Iterative, handshaked SEA(96,8) decryption core; the multi-cycle inverse of the team's Feistel encryptor on 48-bit halves.
- Executes one Feistel round per clock.
- Accepts a ciphertext pair plus a 48-bit key over a valid/ready input channel and returns the plaintext pair over a valid/ready output channel.
- Sits behind the bus/IO shim in place of the flat combinational decryptor to cut area.

Parameters:
- NR, 52, number of Feistel rounds, legal range 1..255.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ciphertext/key offer.
- in_ready  out  1  core can accept; high only in IDLE.
- ci_l  in  48  ciphertext left half.
- ci_r  in  48  ciphertext right half.
- ki  in  48  cipher key.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts plaintext.
- pt_l  out  48  plaintext left half.
- pt_r  out  48  plaintext right half.
- busy  out  1  high in RUN.

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - state=IDLE, round counter=0.
  - L/R/key registers=0, pt_l=pt_r=0.
  - out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
- Word view: word j = bits [8j+7:8j], j=0..5.
- Operators:
  - x⊞k: per-word add mod 256, no carry between words.
  - S: bitsliced per triple m (words 3m,3m+1,3m+2) and bit p. Nibble {w3m+2[p],w3m+1[p],w3m[p]} maps through table 0→0,1→5,2→6,3→7,4→4,5→3,6→1,7→2.
  - r: word 3m rotate right 1 bit; word 3m+2 rotate left 1 bit; word 3m+1 unchanged.
  - R^-1: word j ← word j+1; word5 ← word0.
- Round key: K_i = ki XOR {40'b0, i[7:0]}.
- Decryption round, i = NR-1 down to 0:
  - L' = R^-1(R XOR r(S(L ⊞ K_i)))
  - R' = L
- FSM:
  - IDLE: on in_valid & in_ready, capture L=ci_l, R=ci_r, key=ki, counter=NR-1, go RUN. Input is ignored while not in IDLE.
  - RUN: each cycle apply round(counter). If counter==0, load pt_l=L', pt_r=R', go DONE. Otherwise decrement counter.
  - DONE: out_valid=1. pt_l/pt_r are held stable until out_ready. On out_ready, go IDLE and drop out_valid.
- Latency: accept edge to out_valid high = NR cycles.
- Throughput: one block per NR+2 cycles with out_ready tied high.
- ki changes during RUN have no effect; the key is latched at accept.
- Back-to-back: in_ready is low in DONE, so the next accept occurs no earlier than the cycle after out_ready.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial block is lost and out_valid never asserts for it.
- NR=1: DONE is reached one cycle after accept.

Optional Feature:
- Macro SEA_ITER_ABORT_EN.
- When defined: adds input port abort (1 bit).
  - abort high in RUN or DONE forces IDLE next cycle.
  - Clears out_valid and pt_l/pt_r to 0.
  - Counter returns to 0.
  - abort in IDLE has no effect.
  - If abort and in_valid are both high in IDLE, the accept proceeds.
- When undefined: no abort port, and the FSM is exactly as above.

Test Plan:
- NR=1, ci_l=0, ci_r=0, ki=0 → after 1 cycle out_valid=1, pt_l=0, pt_r=0.
- NR=1, ci_l=0, ci_r=0, ki=48'h000000000001 → pt_l=48'h800000000200, pt_r=0.
- NR=52, random pairs: encrypt through the team encryptor model, feed the result in, and hold out_ready high → pt equals the original plaintext, out_valid rises exactly 52 cycles after accept, and in_ready is low throughout RUN/DONE.
- NR=52, hold out_ready low for 10 cycles in DONE → pt_l/pt_r/out_valid stable. A second in_valid pulse is not accepted until the cycle after out_ready.
- rst_n pulsed low at round 20 → all outputs 0 immediately, in_ready=1. A subsequent block decrypts correctly with no residue.
- SEA_ITER_ABORT_EN defined, abort at round 10 → next cycle IDLE, out_valid never rises. The following block completes in 52 cycles.
